// File: rtl/grid_bank_pkg.sv
// Shared types and default geometry for the grid memory bank responder.
// Round-robin arbitration is selected with the GRID_BANK_RR_ARB_EN macro.
package grid_bank_pkg;

  localparam int TX_W             = 16;
  localparam int BANK_DEPTH       = 8;
  localparam int GRID_VEC_ALIGN_N = 64;
  localparam int N_PORTS_DEF      = 4;
  localparam int CHUNKS           = GRID_VEC_ALIGN_N / TX_W;
  localparam int PORT_W           = $clog2(N_PORTS_DEF);
  localparam int WIDX_W           = $clog2(BANK_DEPTH * CHUNKS);

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Everything stage 2 needs, captured at the grant edge.
  typedef struct packed {
    logic [PORT_W-1:0] port;
    op_e               op;
    logic [WIDX_W-1:0] widx;
    logic [TX_W-1:0]   wdata;
    logic              oob;
  } grant_t;

endpackage

// File: rtl/grid_bank_arb.sv
// One-hot single-grant arbiter for the grid bank.
// GRID_BANK_RR_ARB_EN selects round-robin with a pointer; otherwise lowest index wins.
module grid_bank_arb #(
  parameter int N_PORTS = 4
) (
`ifdef GRID_BANK_RR_ARB_EN
  input  logic               clock,
  input  logic               reset_n,
`endif
  input  logic [N_PORTS-1:0] req,
  output logic [N_PORTS-1:0] gnt
);

`ifdef GRID_BANK_RR_ARB_EN
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [PW-1:0] ptr_d, ptr_q;
  logic          found;
  int            idx;

  // Search starts at the pointer and wraps; pointer moves past the winner.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = (int'(ptr_q) + k) % N_PORTS;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_d    = PW'((idx + 1) % N_PORTS);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
`else
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/grid_bank_server.sv
// Grid bank responder: two-stage arbitrated access to single-ported row storage.
// Build with GRID_BANK_RR_ARB_EN for round-robin; default is fixed priority.
module grid_bank_server #(
  parameter  int N_PORTS = grid_bank_pkg::N_PORTS_DEF,
  parameter  int DEPTH   = grid_bank_pkg::BANK_DEPTH,
  parameter  int ROW_W   = grid_bank_pkg::GRID_VEC_ALIGN_N,
  parameter  int TX_W    = grid_bank_pkg::TX_W,
  localparam int RA_W    = $clog2(DEPTH + 1),
  localparam int CA_W    = $clog2(ROW_W)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [N_PORTS-1:0]            read_en,
  input  logic [N_PORTS-1:0]            write_en,
  input  logic [N_PORTS-1:0][RA_W-1:0]  row_addr,
  input  logic [N_PORTS-1:0][CA_W-1:0]  col_addr,
  input  logic [N_PORTS-1:0][TX_W-1:0]  wdata,
  output logic [N_PORTS-1:0]            ack,
  output logic [TX_W-1:0]               rdata,
  output logic                          busy
);
  import grid_bank_pkg::*;

  localparam int ROW_CHUNKS = ROW_W / TX_W;
  localparam int N_WORDS    = DEPTH * ROW_CHUNKS;
  localparam int TX_LOG     = $clog2(TX_W);

  logic [N_PORTS-1:0] req, gnt;
  grant_t             grant_d, grant_q;
  logic               valid_d, valid_q;
  logic [31:0]        row_ext, col_ext;
  logic [TX_W-1:0]    mem [N_WORDS];

  // The port being acked this cycle still shows its old request level.
  assign req = (read_en | write_en) & ~ack;

  grid_bank_arb #(.N_PORTS(N_PORTS)) u_arb (
`ifdef GRID_BANK_RR_ARB_EN
    .clock   (clock),
    .reset_n (reset_n),
`endif
    .req     (req),
    .gnt     (gnt)
  );

  // Next state: capture the winner's address, data and op.
  always_comb begin
    grant_d = '0;
    valid_d = |gnt;
    row_ext = '0;
    col_ext = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (gnt[p]) begin
        row_ext       = 32'(row_addr[p]);
        col_ext       = 32'(col_addr[p]);
        grant_d.port  = PORT_W'(p);
        grant_d.op    = write_en[p] ? OP_WR : OP_RD;
        grant_d.wdata = wdata[p];
        grant_d.oob   = (row_ext >= 32'(DEPTH)) || (col_ext >= 32'(ROW_W));
        grant_d.widx  = WIDX_W'(row_ext * 32'(ROW_CHUNKS) + (col_ext >> TX_LOG));
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      grant_q <= '0;
    end else begin
      valid_q <= valid_d;
      grant_q <= grant_d;
    end
  end

  // Write lands at the end of the ack cycle, so rdata shows the old word.
  always_ff @(posedge clock) begin
    if (valid_q && grant_q.op == OP_WR && !grant_q.oob)
      mem[grant_q.widx] <= grant_q.wdata;
  end

  always_comb begin
    ack   = '0;
    rdata = '0;
    if (valid_q) begin
      ack[grant_q.port] = 1'b1;
      if (!grant_q.oob) rdata = mem[grant_q.widx];
    end
  end

  assign busy = valid_q;

endmodule

// File: tb/tb_grid_bank_server.sv
// Directed table-driven bench for grid_bank_server, plus reset-abort and contention sequences.
module tb_grid_bank_server;

  localparam int NP   = 4;
  localparam int RA_W = 4;
  localparam int CA_W = 6;
  localparam int TXW  = 16;

  logic                      clock = 1'b0;
  logic                      reset_n = 1'b0;
  logic [NP-1:0]             read_en = '0;
  logic [NP-1:0]             write_en = '0;
  logic [NP-1:0][RA_W-1:0]   row_addr = '0;
  logic [NP-1:0][CA_W-1:0]   col_addr = '0;
  logic [NP-1:0][TXW-1:0]    wdata = '0;
  logic [NP-1:0]             ack;
  logic [TXW-1:0]            rdata;
  logic                      busy;

  grid_bank_server dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .read_en  (read_en),
    .write_en (write_en),
    .row_addr (row_addr),
    .col_addr (col_addr),
    .wdata    (wdata),
    .ack      (ack),
    .rdata    (rdata),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic           rd;
    logic           wr;
    int             port;
    int             row;
    int             col;
    logic [TXW-1:0] wd;
    logic           chk_rd;
    logic [TXW-1:0] exp_rd;
  } vec_t;

  vec_t vt [13];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    @(negedge clock);
    read_en            = '0;
    write_en           = '0;
    read_en[v.port]    = v.rd;
    write_en[v.port]   = v.wr;
    row_addr[v.port]   = RA_W'(v.row);
    col_addr[v.port]   = CA_W'(v.col);
    wdata[v.port]      = v.wd;
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (ack == '0 && lat < 4);
    check({tag, " latency"}, 32'(lat), 32'd1);
    check({tag, " ack"}, 32'(ack), 32'(1) << v.port);
    if (v.chk_rd) check({tag, " rdata"}, 32'(rdata), 32'(v.exp_rd));
    read_en  = '0;
    write_en = '0;
    @(posedge clock);
    #1;
    check({tag, " single ack"}, 32'(ack), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int   exp_p;
    vec_t v;

    //        rd    wr    port row col  wdata     chk   exp
    vt[0]  = '{1'b0, 1'b1, 0, 2,  16, 16'hBEEF, 1'b0, 16'h0000};
    vt[1]  = '{1'b1, 1'b0, 0, 2,  16, 16'h0000, 1'b1, 16'hBEEF};
    vt[2]  = '{1'b0, 1'b1, 1, 2,  17, 16'h00FF, 1'b1, 16'hBEEF};
    vt[3]  = '{1'b1, 1'b0, 2, 2,  31, 16'h0000, 1'b1, 16'h00FF};
    vt[4]  = '{1'b0, 1'b1, 3, 0,  0,  16'h0001, 1'b0, 16'h0000};
    vt[5]  = '{1'b0, 1'b1, 3, 7,  48, 16'hA5A5, 1'b0, 16'h0000};
    vt[6]  = '{1'b1, 1'b0, 1, 7,  63, 16'h0000, 1'b1, 16'hA5A5};
    vt[7]  = '{1'b1, 1'b0, 0, 8,  16, 16'h0000, 1'b1, 16'h0000};
    vt[8]  = '{1'b0, 1'b1, 2, 8,  0,  16'hFFFF, 1'b1, 16'h0000};
    vt[9]  = '{1'b1, 1'b0, 3, 15, 0,  16'h0000, 1'b1, 16'h0000};
    vt[10] = '{1'b1, 1'b0, 1, 0,  0,  16'h0000, 1'b1, 16'h0001};
    vt[11] = '{1'b1, 1'b1, 0, 2,  16, 16'h1234, 1'b1, 16'h00FF};
    vt[12] = '{1'b1, 1'b0, 1, 2,  16, 16'h0000, 1'b1, 16'h1234};

    repeat (3) @(posedge clock);
    #1;
    check("reset ack", 32'(ack), 32'd0);
    check("reset rdata", 32'(rdata), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Reset between grant and the write taking effect.
    v = '{1'b0, 1'b1, 2, 3, 0, 16'h5555, 1'b0, 16'h0000};
    run_vec(v, "pre-abort write");
    @(negedge clock);
    write_en[2] = 1'b1;
    row_addr[2] = RA_W'(3);
    col_addr[2] = CA_W'(0);
    wdata[2]    = 16'h9999;
    @(posedge clock);
    #1;
    check("abort granted busy", 32'(busy), 32'd1);
    reset_n  = 1'b0;
    write_en = '0;
    #1;
    check("abort ack", 32'(ack), 32'd0);
    check("abort rdata", 32'(rdata), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    v = '{1'b1, 1'b0, 2, 3, 0, 16'h0000, 1'b1, 16'h5555};
    run_vec(v, "post-abort read");

    // All ports reading continuously from a fresh reset.
    pulse_reset();
    @(negedge clock);
    for (int p = 0; p < NP; p++) begin
      row_addr[p] = RA_W'(p);
      col_addr[p] = '0;
    end
    read_en = '1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock);
      #1;
`ifdef GRID_BANK_RR_ARB_EN
      exp_p = c % 4;
`else
      exp_p = c % 2;
`endif
      check($sformatf("contend c%0d ack", c), 32'(ack), 32'(1) << exp_p);
      check($sformatf("contend c%0d busy", c), 32'(busy), 32'd1);
    end
    @(negedge clock);
    read_en = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
